// File: rtl/multi_stack.sv
// multi_stack: NCH independent LIFO channels with cached TOS, shared op port, depth/full/empty and sticky ovf/udf flags
// Optional STACK_PICK_EN adds a combinational pick_idx read port; undefined ties pick_o to 0.
module multi_stack #(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int DSZ   = 32,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int DW   = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [CW-1:0]  ch,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] s0,
  output logic [DW-1:0]  depth,
  output logic           empty,
  output logic           full,
  output logic [NCH-1:0] ovf,
  output logic [NCH-1:0] udf,
  input  logic [AW-1:0]  pick_idx,
  output logic [DSZ-1:0] pick_o
);
  logic [DSZ-1:0] t_q [NCH];
  logic [DSZ-1:0] t_d [NCH];
  logic [DW-1:0]  n_q [NCH];
  logic [DW-1:0]  n_d [NCH];
  logic [NCH-1:0] ovf_q, ovf_d, udf_q, udf_d;
  logic [DSZ-1:0] m_q [NCH][DEPTH-1];
  logic [DW-1:0]  n_c;
  logic [DSZ-1:0] t_c;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic           push, pop, repl, mem_we;
  always_comb begin
    n_c    = n_q[ch];
    t_c    = t_q[ch];
    wr_idx = AW'(n_c - DW'(1));
    rd_idx = AW'(n_c - DW'(2));
    push   = en && op == 2'b01;
    pop    = en && op == 2'b10;
    repl   = en && op == 2'b11;
    empty  = n_c == '0;
    full   = n_c == DW'(DEPTH);
    depth  = n_c;
    tos    = t_c;
    s0     = (n_c >= DW'(2)) ? m_q[ch][rd_idx] : '0;
    ovf    = ovf_q;
    udf    = udf_q;
    mem_we = push && !full && !empty;
  end
  always_comb begin
    t_d   = t_q;
    n_d   = n_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (push) begin
      if (full) ovf_d[ch] = 1'b1;
      else begin
        t_d[ch] = vi;
        n_d[ch] = n_c + DW'(1);
      end
    end
    if (pop) begin
      if (empty) udf_d[ch] = 1'b1;
      else begin
        t_d[ch] = s0;
        n_d[ch] = n_c - DW'(1);
      end
    end
    if (repl) begin
      if (empty) udf_d[ch] = 1'b1;
      else t_d[ch] = vi;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q   <= '{default: '0};
      n_q   <= '{default: '0};
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      t_q   <= t_d;
      n_q   <= n_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  // Cell storage is deliberately left uncleared by reset; depth bounds every read.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) m_q[ch][wr_idx] <= t_c;
  end
`ifdef STACK_PICK_EN
  logic [AW-1:0] pk_idx;
  always_comb begin
    pk_idx = AW'(n_c - DW'(1) - {1'b0, pick_idx});
    pick_o = ({1'b0, pick_idx} >= n_c) ? '0 : (pick_idx == '0) ? t_c : m_q[ch][pk_idx];
  end
`else
  assign pick_o = '0;
`endif
endmodule
